// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
// Shared definitions for the SPI command deframer:
//   - state_t    : deframer FSM states
//   - CMD_*      : command opcodes (byte 0 of a frame)
//   - LEN_*      : payload length in bytes for each command
//   - cmd_len()  : payload length of an opcode, 0 for an unknown opcode
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EXEC    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [7:0] CMD_PIXEL  = 8'h50;
  localparam logic [7:0] CMD_BRIGHT = 8'h42;
  localparam logic [7:0] CMD_FILL   = 8'h46;

  localparam logic [2:0] LEN_PIXEL  = 3'd5;
  localparam logic [2:0] LEN_BRIGHT = 3'd1;
  localparam logic [2:0] LEN_FILL   = 3'd3;

  // A zero length doubles as the "unknown command" marker since every
  // valid command carries at least one payload byte.
  function automatic logic [2:0] cmd_len(input logic [7:0] cmd);
    logic [2:0] len;
    len = 3'd0;
    case (cmd)
      CMD_PIXEL:  len = LEN_PIXEL;
      CMD_BRIGHT: len = LEN_BRIGHT;
      CMD_FILL:   len = LEN_FILL;
      default:    len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_cmd_deframer_sync.sv
// sync_edge_detect
// Brings an asynchronous level into clk through a SYNC_STAGES flop chain
// and flags its edges.
// Ports:
//   clk, reset  : fabric clock, synchronous active-high reset
//   async_in    : asynchronous level input
//   sync_out    : synchronized level (last chain stage)
//   rise / fall : one-cycle edge flags of sync_out
// RESET_VAL sets the level the chain and edge history come out of reset
// with, so an input already idling at that level produces no edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_in;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_cmd_deframer.sv
// spi_cmd_deframer
// Parses SPI command frames (delimited by ss) from the spi_slave byte
// stream and emits one-cycle write strobes toward the LED framebuffer.
// Ports:
//   clk, reset            : fabric clock, synchronous active-high reset
//   slv_done, slv_rdata   : spi_slave byte-complete level and byte (async)
//   ss                    : SPI slave select, active low (async)
//   pix_we/pix_row/pix_col: pixel write strobe and coordinates
//   pix_rgb               : {R,G,B} for pixel writes and fills
//   bright_we/bright_val  : brightness strobe and held value
//   fill_req              : fill-whole-panel strobe
//   frame_err             : bad command, out-of-range pixel, or short frame
//   busy                  : FSM not in IDLE
module spi_cmd_deframer
  import spi_cmd_pkg::*;
#(
  parameter int ROWS        = 32,
  parameter int COLS        = 64,
  parameter int ROW_W       = 5,
  parameter int COL_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slv_done,
  input  logic [7:0]       slv_rdata,
  input  logic             ss,
  output logic             pix_we,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic [23:0]      pix_rgb,
  output logic             bright_we,
  output logic [7:0]       bright_val,
  output logic             fill_req,
  output logic             frame_err,
  output logic             busy
);

  // Synchronizers
  logic done_sync, done_rise, done_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic unused_sync;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_done_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (slv_done),
    .sync_out (done_sync),
    .rise     (done_rise),
    .fall     (done_fall)
  );

  // ss idles high, so it comes out of reset high to avoid a false frame end.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ss),
    .sync_out (ss_sync),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  assign unused_sync = ^{done_sync, done_fall, ss_sync, ss_fall};

  // State
  logic             byte_stb_q, byte_stb_d;
  logic             ss_rise_q, ss_rise_d;
  logic [7:0]       byte_q, byte_d;
  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      opr_q, opr_d;
  logic             end_q, end_d;
  logic [39:0]      opr_shift;

  logic             pix_we_q, pix_we_d;
  logic [ROW_W-1:0] pix_row_q, pix_row_d;
  logic [COL_W-1:0] pix_col_q, pix_col_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             bright_we_q, bright_we_d;
  logic [7:0]       bright_val_q, bright_val_d;
  logic             fill_req_q, fill_req_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  always_comb begin
    // rdata is captured on the same cycle the done edge is seen; the FSM
    // consumes it one cycle later together with the registered strobe.
    byte_stb_d   = done_rise;
    ss_rise_d    = ss_rise;
    byte_d       = done_rise ? slv_rdata : byte_q;

    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    opr_d        = opr_q;
    end_d        = end_q;

    pix_we_d     = 1'b0;
    bright_we_d  = 1'b0;
    fill_req_d   = 1'b0;
    frame_err_d  = 1'b0;
    pix_row_d    = pix_row_q;
    pix_col_d    = pix_col_q;
    pix_rgb_d    = pix_rgb_q;
    bright_val_d = bright_val_q;

    // Operands accumulate MSB-first; for a pixel the row lands in [39:32],
    // column in [31:24] and colour in [23:0] once the last byte arrives.
    opr_shift    = {opr_q, byte_q};

    case (state_q)
      IDLE: begin
        if (byte_stb_q) begin
          if (cmd_len(byte_q) != 3'd0) begin
            cmd_d   = byte_q;
            cnt_d   = cmd_len(byte_q);
            opr_d   = '0;
            end_d   = 1'b0;
            state_d = PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end
        end
      end

      PAYLOAD: begin
        if (byte_stb_q) begin
          opr_d = opr_shift[31:0];
          cnt_d = cnt_q - 3'd1;
        end
        // A byte arriving with ss_rise is processed first; only if it does
        // not complete the payload is the frame short.
        if (byte_stb_q && cnt_q == 3'd1) begin
          state_d = EXEC;
          end_d   = ss_rise_q;
          // Strobes are registered, so deciding them here makes them
          // visible exactly during the EXEC cycle.
          case (cmd_q)
            CMD_PIXEL: begin
              if (int'(opr_shift[39:32]) < ROWS && int'(opr_shift[31:24]) < COLS) begin
                pix_we_d  = 1'b1;
                pix_row_d = opr_shift[32 +: ROW_W];
                pix_col_d = opr_shift[24 +: COL_W];
                pix_rgb_d = opr_shift[23:0];
              end else begin
                frame_err_d = 1'b1;
              end
            end
            CMD_BRIGHT: begin
              bright_we_d  = 1'b1;
              bright_val_d = opr_shift[7:0];
            end
            CMD_FILL: begin
              fill_req_d = 1'b1;
              pix_rgb_d  = opr_shift[23:0];
            end
            default: frame_err_d = 1'b1;
          endcase
        end else if (ss_rise_q) begin
          frame_err_d = 1'b1;
          opr_d       = '0;
          state_d     = IDLE;
        end
      end

      EXEC: begin
        // Frame already closed (with the last byte or now): skip DRAIN.
        state_d = (end_q || ss_rise_q) ? IDLE : DRAIN;
      end

      DRAIN: begin
        if (ss_rise_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_stb_q   <= 1'b0;
      ss_rise_q    <= 1'b0;
      byte_q       <= '0;
      state_q      <= IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      opr_q        <= '0;
      end_q        <= 1'b0;
      pix_we_q     <= 1'b0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      pix_rgb_q    <= '0;
      bright_we_q  <= 1'b0;
      bright_val_q <= 8'hFF;
      fill_req_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      byte_stb_q   <= byte_stb_d;
      ss_rise_q    <= ss_rise_d;
      byte_q       <= byte_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      opr_q        <= opr_d;
      end_q        <= end_d;
      pix_we_q     <= pix_we_d;
      pix_row_q    <= pix_row_d;
      pix_col_q    <= pix_col_d;
      pix_rgb_q    <= pix_rgb_d;
      bright_we_q  <= bright_we_d;
      bright_val_q <= bright_val_d;
      fill_req_q   <= fill_req_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_row    = pix_row_q;
  assign pix_col    = pix_col_q;
  assign pix_rgb    = pix_rgb_q;
  assign bright_we  = bright_we_q;
  assign bright_val = bright_val_q;
  assign fill_req   = fill_req_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_cmd_deframer.sv
// Directed testbench for spi_cmd_deframer.
module tb_spi_cmd_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slv_done = 1'b0;
  logic [7:0] slv_rdata = 8'h00;
  logic       ss = 1'b1;

  logic       pix_we;
  logic [4:0] pix_row;
  logic [5:0] pix_col;
  logic [23:0] pix_rgb;
  logic       bright_we;
  logic [7:0] bright_val;
  logic       fill_req;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  spi_cmd_deframer dut (
    .clk        (clk),
    .reset      (reset),
    .slv_done   (slv_done),
    .slv_rdata  (slv_rdata),
    .ss         (ss),
    .pix_we     (pix_we),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_rgb    (pix_rgb),
    .bright_we  (bright_we),
    .bright_val (bright_val),
    .fill_req   (fill_req),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Strobe monitor: counts high cycles of each strobe, captures values.
  int pix_cnt = 0, bright_cnt = 0, fill_cnt = 0, err_cnt = 0, ovl_cnt = 0;
  logic [4:0]  cap_row = '0;
  logic [5:0]  cap_col = '0;
  logic [23:0] cap_rgb = '0;
  logic [23:0] cap_fill_rgb = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_we) begin
        pix_cnt++;
        cap_row = pix_row;
        cap_col = pix_col;
        cap_rgb = pix_rgb;
      end
      if (bright_we) bright_cnt++;
      if (fill_req) begin
        fill_cnt++;
        cap_fill_rgb = pix_rgb;
      end
      if ((int'(pix_we) + int'(bright_we) + int'(fill_req) + int'(frame_err)) > 1) ovl_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;
  int b_pix, b_br, b_fill, b_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic snap();
    b_pix  = pix_cnt;
    b_br   = bright_cnt;
    b_fill = fill_cnt;
    b_err  = err_cnt_now();
  endtask

  function automatic int err_cnt_now();
    return err_cnt;
  endfunction

  always @(negedge clk) if (!reset && frame_err) err_cnt++;

  task automatic send_byte(input logic [7:0] b);
    slv_rdata = b;
    #2;
    slv_done = 1'b1;
    repeat (6) @(posedge clk);
    slv_done = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic frame_end();
    ss = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pix_we", 32'(pix_we), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bright_val", 32'(bright_val), 32'hFF);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'h0);
    chk("rst_pix_row", 32'(pix_row), 32'h0);

    // Pixel write 50 03 0A 11 22 33
    snap();
    frame_begin();
    send_byte(8'h50); send_byte(8'h03); send_byte(8'h0A);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    chk("pix_busy_drain", 32'(busy), 32'h1);
    frame_end();
    chk("pix_count", 32'(pix_cnt - b_pix), 32'd1);
    chk("pix_err", 32'(err_cnt - b_err), 32'd0);
    chk("pix_row", 32'(cap_row), 32'd3);
    chk("pix_col", 32'(cap_col), 32'd10);
    chk("pix_rgb", 32'(cap_rgb), 32'h112233);
    chk("pix_busy_idle", 32'(busy), 32'h0);

    // Brightness 42 80
    snap();
    frame_begin();
    send_byte(8'h42); send_byte(8'h80);
    frame_end();
    chk("bright_count", 32'(bright_cnt - b_br), 32'd1);
    chk("bright_val", 32'(bright_val), 32'h80);

    // Fill with trailing junk 46 FF 00 7F 99 99
    snap();
    frame_begin();
    send_byte(8'h46); send_byte(8'hFF); send_byte(8'h00);
    send_byte(8'h7F); send_byte(8'h99); send_byte(8'h99);
    frame_end();
    chk("fill_count", 32'(fill_cnt - b_fill), 32'd1);
    chk("fill_rgb", 32'(cap_fill_rgb), 32'hFF007F);
    chk("fill_no_pix", 32'(pix_cnt - b_pix), 32'd0);
    chk("fill_no_bright", 32'(bright_cnt - b_br), 32'd0);
    chk("fill_err", 32'(err_cnt - b_err), 32'd0);

    // Unknown command 13 followed by a would-be pixel frame
    snap();
    frame_begin();
    send_byte(8'h13); send_byte(8'h50); send_byte(8'h03);
    send_byte(8'h0A); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    chk("unk_err", 32'(err_cnt - b_err), 32'd1);
    chk("unk_no_pix", 32'(pix_cnt - b_pix), 32'd0);
    chk("unk_busy", 32'(busy), 32'h1);
    frame_end();
    chk("unk_no_writes", 32'((bright_cnt - b_br) + (fill_cnt - b_fill)), 32'd0);
    chk("unk_busy_idle", 32'(busy), 32'h0);

    // Pixel with row = 32 (out of range)
    snap();
    frame_begin();
    send_byte(8'h50); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    frame_end();
    chk("row32_err", 32'(err_cnt - b_err), 32'd1);
    chk("row32_no_pix", 32'(pix_cnt - b_pix), 32'd0);

    // Short frame 50 01 02 then next frame 42 10
    snap();
    frame_begin();
    send_byte(8'h50); send_byte(8'h01); send_byte(8'h02);
    frame_end();
    chk("short_err", 32'(err_cnt - b_err), 32'd1);
    chk("short_no_pix", 32'(pix_cnt - b_pix), 32'd0);
    chk("short_busy", 32'(busy), 32'h0);
    snap();
    frame_begin();
    send_byte(8'h42); send_byte(8'h10);
    frame_end();
    chk("after_short_bright", 32'(bright_cnt - b_br), 32'd1);
    chk("after_short_val", 32'(bright_val), 32'h10);

    // Reset mid-PAYLOAD, then 42 20 within the same ss-low window
    frame_begin();
    send_byte(8'h50); send_byte(8'h01);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_bright_val", 32'(bright_val), 32'hFF);
    chk("midrst_pix_rgb", 32'(pix_rgb), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    snap();
    send_byte(8'h42); send_byte(8'h20);
    frame_end();
    chk("midrst_bright_count", 32'(bright_cnt - b_br), 32'd1);
    chk("midrst_bright_val2", 32'(bright_val), 32'h20);
    chk("midrst_err", 32'(err_cnt - b_err), 32'd0);

    // Strobes never overlapped anywhere in the run
    chk("strobe_overlap", 32'(ovl_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_deframer.md
Name: spi_cmd_deframer

Overview:
- Sits directly downstream of spi_slave and consumes its received bytes (done level + rdata), which arrive asynchronous to the fabric clock.
- Synchronizes the byte stream into clk and parses command frames delimited by ss.
- Emits one-cycle write strobes for pixel, brightness and fill operations toward the framebuffer/control logic of the LED display.

Parameters:
- ROWS, 32, panel rows; a row index >= ROWS is out of range.
- COLS, 64, panel columns; a column index >= COLS is out of range.
- ROW_W, 5, width of pix_row; ROW_W >= clog2(ROWS).
- COL_W, 6, width of pix_col; COL_W >= clog2(COLS).
- SYNC_STAGES, 2, flop stages on slv_done and ss; minimum 2.

Ports:
- clk  in  1  fabric clock.
- reset  in  1  synchronous, active-high reset.
- slv_done  in  1  spi_slave done, asynchronous level; high once a byte is complete.
- slv_rdata  in  8  spi_slave rdata; stable while slv_done is high.
- ss  in  1  SPI slave select, asynchronous, active low; high means frame boundary.
- pix_we  out  1  one-cycle pixel write strobe.
- pix_row  out  ROW_W  pixel row; valid with pix_we.
- pix_col  out  COL_W  pixel column; valid with pix_we.
- pix_rgb  out  24  {R,G,B}; valid with pix_we and fill_req.
- bright_we  out  1  one-cycle brightness write strobe.
- bright_val  out  8  brightness value; held until the next bright_we.
- fill_req  out  1  one-cycle fill-whole-panel request, colour on pix_rgb.
- frame_err  out  1  one-cycle pulse on unknown command, out-of-range coordinate, or short frame.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchronization
  - slv_done and ss each pass through SYNC_STAGES flops.
  - A byte event (byte_stb) is the rising edge of synchronized done, detected one cycle after the last sync stage.
  - slv_rdata is sampled into byte_q on that same cycle; this is safe because rdata is stable while done is high.
  - Frame end (ss_rise) is the rising edge of synchronized ss.
- Commands
  - Byte 0 of a frame is the command:
    - CMD_PIXEL 0x50: payload row, col, R, G, B (5 bytes).
    - CMD_BRIGHT 0x42: payload value (1 byte).
    - CMD_FILL 0x46: payload R, G, B (3 bytes).
- FSM states: IDLE, PAYLOAD, EXEC, DRAIN.
  - IDLE: on byte_stb, decode byte_q.
    - Known command: latch the command, load byte counter = payload length, go to PAYLOAD.
    - Unknown command: pulse frame_err, go to DRAIN.
  - PAYLOAD: on each byte_stb, shift byte_q into the operand register and decrement the counter. When the counter reaches 0, go to EXEC.
  - EXEC (exactly one cycle):
    - PIXEL: if row < ROWS and col < COLS, pulse pix_we; otherwise pulse frame_err.
    - BRIGHT: pulse bright_we and update bright_val.
    - FILL: pulse fill_req.
    - Then go to DRAIN.
  - DRAIN: ignore all further bytes; go to IDLE on ss_rise.
- Frame end handling
  - ss_rise in PAYLOAD: pulse frame_err, discard operands, go to IDLE (short frame).
  - ss_rise in IDLE: no effect.
- Latency: the last payload byte_stb is followed by the output strobe on the next clock (EXEC cycle).
- Simultaneous events
  - ss_rise and byte_stb in the same cycle in PAYLOAD: process the byte first. If it completes the payload, go to EXEC and then IDLE, with no error; otherwise treat as a short frame.
  - ss_rise in EXEC: the strobe still fires, then the FSM goes to IDLE.
- Strobes (pix_we, bright_we, fill_req, frame_err) are never high for more than one cycle, and never high together except frame_err alone.
- Reset
  - All strobes 0, busy 0, pix_row/pix_col/pix_rgb 0, bright_val 0xFF, FSM IDLE, sync flops cleared.
  - Synchronized ss is reset to 1 and synchronized done to 0, so no false edge occurs after reset.
  - Reset mid-frame: the partial frame is discarded, and following bytes of that frame are parsed as a new command. The host is responsible for re-framing.

Decomposition:
- Package spi_cmd_pkg holds:
  - the state typedef enum {IDLE, PAYLOAD, EXEC, DRAIN};
  - the CMD_PIXEL/CMD_BRIGHT/CMD_FILL localparams;
  - the payload-length constants LEN_PIXEL=5, LEN_BRIGHT=1, LEN_FILL=3.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES, outputs sync level, rise, fall), instantiated for slv_done and ss.

Test Plan:
- Pixel write: frame 50 03 0A 11 22 33, then ss high -> single pix_we with row=3, col=10, rgb=0x112233; frame_err stays 0.
- Brightness: frame 42 80 -> bright_we once, bright_val=0x80 held; after reset, bright_val=0xFF.
- Fill plus trailing junk: frame 46 FF 00 7F 99 99 -> fill_req once with rgb=0xFF007F; extra bytes produce no strobes.
- Errors:
  - Unknown command 0x13 -> frame_err once, no write strobes until ss high.
  - Pixel with row=32 (ROWS=32) -> frame_err, no pix_we.
- Short frame: 50 01 02 then ss high -> frame_err once, no pix_we; next frame 42 10 -> bright_val=0x10.
- Reset mid-PAYLOAD after 50 01 -> all outputs at reset values, busy=0; a following complete frame 42 20 -> bright_we with 0x20.
